// File: rtl/seed_modadd_serial_if.sv
// Byte-stream bundle for the serial SEED modulo-2^32 adder.
// master drives operand bytes and word controls; slave returns sum bytes.
interface seed_modadd_serial_if;
    logic       start;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       b_sel;
    logic       store;
    logic [7:0] outp;
    logic       out_valid;
    logic       out_last;
    logic       busy;

    modport master (
        output start, in_a, in_b, b_sel, store,
        input  outp, out_valid, out_last, busy
    );

    modport slave (
        input  start, in_a, in_b, b_sel, store,
        output outp, out_valid, out_last, busy
    );
endinterface

// File: rtl/seed_modadd_serial.sv
// Byte-serial modulo-2^32 adder (LSB first) for the SEED F-function.
// Define SEED_MODADD_BUFFER_EN to build the 4-byte operand-B word buffer.
module seed_modadd_serial (
    input  logic                  clk,
    input  logic                  reset,
    seed_modadd_serial_if.slave   bus
);
    typedef enum logic {StIdle, StActive} state_e;

    state_e     r_state, w_state_next;
    logic [1:0] r_cnt, w_cnt_next, w_idx;
    logic       r_carry, w_cin, w_fire;
    logic [7:0] r_outp, w_opb;
    logic [8:0] w_sum9;
    logic       r_out_valid, r_out_last;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_fire       = 1'b0;
        w_idx        = 2'd0;
        w_cin        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_fire       = 1'b1;
                    w_state_next = StActive;
                    w_cnt_next   = 2'd1;
                end
            end
            StActive: begin
                // start is ignored here: the inputs are simply the next data byte
                w_fire     = 1'b1;
                w_idx      = r_cnt;
                w_cin      = r_carry;
                w_cnt_next = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_state_next = StIdle;
                end
            end
            default: ;
        endcase
    end

`ifdef SEED_MODADD_BUFFER_EN
    logic       r_b_sel_q, r_store_q, w_bsel, w_store;
    logic [7:0] r_buf [4];

    always_comb begin
        w_bsel  = (r_state == StActive) ? r_b_sel_q : bus.b_sel;
        w_store = (r_state == StActive) ? r_store_q : bus.store;
        w_opb   = w_bsel ? r_buf[w_idx] : bus.in_b;
    end

    // Read-before-write: the operand above uses the pre-edge buffer byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_sel_q <= 1'b0;
            r_store_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            if (r_state == StIdle && bus.start) begin
                r_b_sel_q <= bus.b_sel;
                r_store_q <= bus.store;
            end
            if (w_fire && w_store) begin
                r_buf[w_idx] <= w_sum9[7:0];
            end
        end
    end
`else
    always_comb begin
        w_opb = bus.in_b;
    end
`endif

    always_comb begin
        w_sum9 = {1'b0, bus.in_a} + {1'b0, w_opb} + {8'd0, w_cin};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= 2'd0;
            r_carry     <= 1'b0;
            r_outp      <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_out_valid <= w_fire;
            r_out_last  <= w_fire && (w_idx == 2'd3);
            if (w_fire) begin
                r_outp  <= w_sum9[7:0];
                r_carry <= w_sum9[8];
            end
        end
    end

    assign bus.outp      = r_outp;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state == StActive);
endmodule

// File: tb/tb_seed_modadd_serial.sv
// Directed scoreboard bench for seed_modadd_serial; buffer cases run only
// when SEED_MODADD_BUFFER_EN is defined, the ignored-controls case otherwise.
module tb_seed_modadd_serial;
    logic clk = 1'b0;
    logic reset;

    seed_modadd_serial_if bus ();

    seed_modadd_serial dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] sb [$];
`ifdef SEED_MODADD_BUFFER_EN
    logic [31:0] m_buf = 32'h0;
`endif

    function automatic void chk(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endfunction

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic tick();
        logic [8:0] e;
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
        if (bus.out_valid && sb.size() != 0) begin
            e = sb.pop_front();
            chk("outp", {24'd0, bus.outp}, {24'd0, e[7:0]});
            chk("out_last", {31'd0, bus.out_last}, {31'd0, e[8]});
        end
    endtask

    task automatic idle();
        bus.start = 1'b0;
        bus.in_a  = 8'h00;
        bus.in_b  = 8'h00;
        bus.b_sel = 1'b0;
        bus.store = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] b,
                             input logic bsel, input logic st,
                             input int glitch_k, input int abort_k);
        logic [31:0] opb;
        logic [31:0] exp;
`ifdef SEED_MODADD_BUFFER_EN
        opb = bsel ? m_buf : b;
`else
        opb = b;
`endif
        exp = a + opb;
        for (int k = 0; k < 4; k++) begin
            bus.start = (k == 0) || (k == glitch_k);
            bus.in_a  = a[8*k +: 8];
            bus.in_b  = b[8*k +: 8];
            bus.b_sel = (k == 0) ? bsel : ~bsel;
            bus.store = (k == 0) ? st : ~st;
            if (k == abort_k) begin
                reset = 1'b1;
                tick();
                chk("rst_outp", {24'd0, bus.outp}, 32'h0);
                chk("rst_busy", {31'd0, bus.busy}, 32'h0);
                chk("rst_last", {31'd0, bus.out_last}, 32'h0);
                reset = 1'b0;
`ifdef SEED_MODADD_BUFFER_EN
                m_buf = 32'h0;
`endif
                bus.start = 1'b0;
                return;
            end
            sb.push_back({k == 3, exp[8*k +: 8]});
            tick();
            chk("busy", {31'd0, bus.busy}, {31'd0, k < 3});
        end
`ifdef SEED_MODADD_BUFFER_EN
        if (st) m_buf = exp;
`endif
        bus.start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in_a  = 8'h00;
        bus.in_b  = 8'h00;
        bus.b_sel = 1'b0;
        bus.store = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk("reset_outp", {24'd0, bus.outp}, 32'h0);
        chk("reset_last", {31'd0, bus.out_last}, 32'h0);
        chk("reset_busy", {31'd0, bus.busy}, 32'h0);
        reset = 1'b0;
        idle();

        // basic add, then wrap followed back-to-back by a fresh word
        send_word(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, -1, -1);
        idle();
        send_word(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, -1, -1);
        send_word(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, -1, -1);
        idle();

`ifdef SEED_MODADD_BUFFER_EN
        send_word(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, -1, -1);
        send_word(32'h0000_0001, 32'hAAAA_AAAA, 1'b1, 1'b0, -1, -1);
        send_word(32'h0000_0001, 32'h5555_5555, 1'b1, 1'b1, -1, -1);
        send_word(32'h0000_0000, 32'h0F0F_0F0F, 1'b1, 1'b0, -1, -1);
        idle();
`endif

        // start pulsed mid-word must not restart or re-latch controls
        send_word(32'h0A0B_0C0D, 32'h01F2_F3F4, 1'b0, 1'b0, 2, -1);
        idle();

        // reset during byte 1 aborts the word
        send_word(32'h1122_33FF, 32'h0000_0001, 1'b0, 1'b1, -1, 1);
        idle();
        send_word(32'h1122_3344, 32'h0000_0055, 1'b1, 1'b0, -1, -1);
        idle();

`ifndef SEED_MODADD_BUFFER_EN
        send_word(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, -1, -1);
        send_word(32'h0000_0007, 32'h0000_00F9, 1'b1, 1'b0, -1, -1);
        idle();
`endif

        idle();
        chk("sb_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
